// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word-addressed memory responder.
// A request is accepted in IDLE, optionally delayed in WAIT by a
// programmable number of cycles, then answered in RESP until the
// requester takes the response. Misaligned or out-of-range requests
// are answered with an error and never touch the memory array.
module mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);
  localparam bit         NO_WAIT  = (LATENCY == 0);

  logic [1:0]    state;
  logic [3:0]    wait_cnt;

  logic          cap_we;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          op_we;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic [AW-1:0] op_word;
  logic          op_err;
  logic [31:0]   rdata_next;
  logic          mem_we;

  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i && (state == IDLE);

  // With zero latency the memory is accessed on the accept edge itself,
  // so the live request inputs are used; otherwise the captured copy is.
  assign enter_resp = (accept && NO_WAIT) ||
                      ((state == WAIT) && (wait_cnt == 4'd1));

  assign op_we    = (state == IDLE) ? req_we_i    : cap_we;
  assign op_addr  = (state == IDLE) ? req_addr_i  : cap_addr;
  assign op_wdata = (state == IDLE) ? req_wdata_i : cap_wdata;
  assign op_word  = op_addr[AW+1:2];
  assign op_err   = (op_addr[1:0] != 2'b00) || (op_addr[31:AW+2] != '0);

  // A write commits only when the response is produced, so an abort by
  // reset while waiting leaves the memory untouched.
  assign mem_we = rst_i && enter_resp && op_we && !op_err;

  // Read data for the response: zero for writes and for errors.
  always_comb begin
    rdata_next = '0;
    if (!op_err && !op_we) begin
      rdata_next = mem[op_word];
    end
  end

  // Capture the request on the accept edge; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      cap_we    <= req_we_i;
      cap_addr  <= req_addr_i;
      cap_wdata <= req_wdata_i;
    end
  end

  // Memory array; deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[op_word] <= op_wdata;
    end
  end

  // Control FSM plus the registered response outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'd0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (NO_WAIT) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= rdata_next;
              rsp_err_o   <= op_err;
            end else begin
              state    <= WAIT;
              wait_cnt <= LAT_LOAD;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (enter_resp) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= rdata_next;
            rsp_err_o   <= op_err;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
          rsp_rdata_o <= 32'd0;
          rsp_err_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: exercises two responders (LATENCY=2 and LATENCY=0)
// with a table of directed vectors, hand-written reset/backpressure
// sequences and randomized traffic scored against a word-array model.
module tb_mem_responder;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  logic [31:0] ref_mem   [2][DEPTH];
  bit          ref_known [2][DEPTH];

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  // Free-running clock shared by both responders.
  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut_lat2 (
    .clk_i      (clk),
    .rst_i      (rst_n[0]),
    .req_valid_i(req_valid[0]),
    .req_ready_o(req_ready[0]),
    .req_we_i   (req_we[0]),
    .req_addr_i (req_addr[0]),
    .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]),
    .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]),
    .rsp_err_o  (rsp_err[0])
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut_lat0 (
    .clk_i      (clk),
    .rst_i      (rst_n[1]),
    .req_valid_i(req_valid[1]),
    .req_ready_o(req_ready[1]),
    .req_we_i   (req_we[1]),
    .req_addr_i (req_addr[1]),
    .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]),
    .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]),
    .rsp_err_o  (rsp_err[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit model_err(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction: accept, wait for the response, optional
  // backpressure, handshake, then score against the model.
  task automatic apply_stimulus(input int k, input bit we,
                                input logic [31:0] addr,
                                input logic [31:0] wdata, input int delay,
                                output logic [31:0] got_rdata,
                                output bit got_err);
    int  cyc;
    int  idx;
    bit  stable;
    bit  exp_err;
    exp_err = model_err(addr);
    idx     = int'(addr / 4);

    @(negedge clk);
    check_output("req_ready_idle", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    rsp_ready[k] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[k] = 1'($urandom_range(0, 1));
    req_we[k]    = 1'($urandom_range(0, 1));
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;

    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid[k] && cyc < 40);
    check_output("rsp_latency_cycles", 32'(cyc), 32'(lat_of(k) + 1));

    got_rdata = rsp_rdata[k];
    got_err   = rsp_err[k];
    stable    = !req_ready[k];
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (!rsp_valid[k] || rsp_rdata[k] !== got_rdata ||
          rsp_err[k] !== got_err || req_ready[k]) begin
        stable = 1'b0;
      end
    end
    check_output("rsp_hold_stable", 32'(stable), 32'd1);

    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    check_output("post_handshake_valid", 32'(rsp_valid[k]), 32'd0);
    check_output("post_handshake_ready", 32'(req_ready[k]), 32'd1);
    rsp_ready[k] = 1'b0;

    check_output("model_err", 32'(got_err), 32'(exp_err));
    if (exp_err || we) begin
      check_output("model_rdata_zero", got_rdata, 32'd0);
    end else if (ref_known[k][idx]) begin
      check_output("model_rdata", got_rdata, ref_mem[k][idx]);
    end
    if (!exp_err && we) begin
      ref_mem[k][idx]   = wdata;
      ref_known[k][idx] = 1'b1;
    end
  endtask

  // Main test sequence.
  initial begin
    logic [31:0] got_rdata;
    bit          got_err;
    logic [31:0] addr;
    int          r;
    int          valid_cnt;
    int          ready_cnt;
    bit          b2b_data_ok;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h1234_5678};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
    vecs[3]  = '{1'b1, 32'h0000_0004, 32'h1111_1111, 1'b0, 32'h0000_0000};
    vecs[4]  = '{1'b0, 32'h0000_0006, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[5]  = '{1'b1, 32'h0000_0006, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
    vecs[6]  = '{1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h1111_1111};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 32'h0000_0200, 32'hBADB_AD00, 1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    vecs[10] = '{1'b0, 32'h0000_0200, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[11] = '{1'b1, 32'h0000_01FC, 32'h0F0F_0F0F, 1'b0, 32'h0000_0000};
    vecs[12] = '{1'b0, 32'h0000_01FC, 32'h0000_0000, 1'b0, 32'h0F0F_0F0F};
    vecs[13] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[14] = '{1'b1, 32'h0000_0003, 32'h7777_7777, 1'b1, 32'h0000_0000};

    for (int k = 0; k < 2; k++) begin
      rst_n[k]     = 1'b0;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
      rsp_ready[k] = 1'b0;
      for (int w = 0; w < DEPTH; w++) begin
        ref_known[k][w] = 1'b0;
        ref_mem[k][w]   = 32'd0;
      end
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_output("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check_output("reset_rsp_rdata", rsp_rdata[k], 32'd0);
      check_output("reset_rsp_err", 32'(rsp_err[k]), 32'd0);
      rst_n[k] = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_output("reset_release_ready", 32'(req_ready[k]), 32'd1);
    end

    $display("[TB] directed vector table");
    for (int k = 0; k < 2; k++) begin
      for (int v = 0; v < 15; v++) begin
        apply_stimulus(k, vecs[v].we, vecs[v].addr, vecs[v].wdata, 0,
                       got_rdata, got_err);
        check_output("vec_err", 32'(got_err), 32'(vecs[v].exp_err));
        check_output("vec_rdata", got_rdata, vecs[v].exp_rdata);
      end
    end

    $display("[TB] backpressure, 5 cycles");
    apply_stimulus(0, 1'b0, 32'h0000_0010, 32'd0, 5, got_rdata, got_err);
    check_output("bp_rdata", got_rdata, 32'h1234_5678);
    apply_stimulus(1, 1'b0, 32'h0000_0200, 32'd0, 5, got_rdata, got_err);
    check_output("bp_err", 32'(got_err), 32'd1);

    $display("[TB] reset during WAIT aborts pending write");
    apply_stimulus(0, 1'b1, 32'h0000_0020, 32'h0102_0304, 0, got_rdata, got_err);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h0000_0020;
    req_wdata[0] = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check_output("wait_ready_low", 32'(req_ready[0]), 32'd0);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check_output("wait_reset_valid", 32'(rsp_valid[0]), 32'd0);
    check_output("wait_reset_rdata", rsp_rdata[0], 32'd0);
    check_output("wait_reset_err", 32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    check_output("wait_reset_ready", 32'(req_ready[0]), 32'd1);
    apply_stimulus(0, 1'b0, 32'h0000_0020, 32'd0, 0, got_rdata, got_err);
    check_output("wait_reset_old_value", got_rdata, 32'h0102_0304);

    $display("[TB] reset during RESP drops response, write already done");
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h0000_0024;
    req_wdata[0] = 32'h55AA_55AA;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check_output("resp_reached", 32'(rsp_valid[0]), 32'd1);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check_output("resp_reset_valid", 32'(rsp_valid[0]), 32'd0);
    rst_n[0] = 1'b1;
    ref_mem[0][9]   = 32'h55AA_55AA;
    ref_known[0][9] = 1'b1;
    apply_stimulus(0, 1'b0, 32'h0000_0024, 32'd0, 0, got_rdata, got_err);
    check_output("resp_reset_committed", got_rdata, 32'h55AA_55AA);

    $display("[TB] zero-latency back-to-back reads");
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'h0000_0010;
    rsp_ready[1] = 1'b1;
    valid_cnt    = 0;
    ready_cnt    = 0;
    b2b_data_ok  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid[1]) begin
        valid_cnt++;
        if (rsp_rdata[1] !== 32'h1234_5678 || rsp_err[1]) b2b_data_ok = 1'b0;
      end
      if (req_ready[1]) ready_cnt++;
    end
    req_valid[1] = 1'b0;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    @(negedge clk);
    check_output("b2b_responses", 32'(valid_cnt), 32'd4);
    check_output("b2b_ready_cycles", 32'(ready_cnt), 32'd4);
    check_output("b2b_rdata", 32'(b2b_data_ok), 32'd1);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 50; t++) begin
        r = int'($urandom_range(0, 9));
        if (r < 7) begin
          addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
        end else if (r == 7) begin
          addr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        end else begin
          addr = $urandom | 32'h0000_0200;
        end
        apply_stimulus(k, 1'($urandom_range(0, 1)), addr, $urandom,
                       int'($urandom_range(0, 3)), got_rdata, got_err);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 128, memory size in 32-bit words (power of two, 4..1024).
REQ-002 Parameter LATENCY, default 2, wait cycles between request accept and response (0..15).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-low.
REQ-005 req_valid_i  input  1  requester presents a request.
REQ-006 req_ready_o  output  1  block can accept a request this cycle.
REQ-007 req_we_i  input  1  1 = write, 0 = read.
REQ-008 req_addr_i  input  32  byte address.
REQ-009 req_wdata_i  input  32  write data.
REQ-010 rsp_valid_o  output  1  response available.
REQ-011 rsp_ready_i  input  1  requester accepts the response.
REQ-012 rsp_rdata_o  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err_o  output  1  request was misaligned or out of range.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP; req_ready_o SHALL be 1 only in IDLE, and rsp_valid_o SHALL be 1 only in RESP.
REQ-015 A request is accepted when req_valid_i and req_ready_o are both 1 at a rising edge; the block SHALL then capture we, addr and wdata into internal registers.
REQ-016 On accept, with LATENCY>0 the FSM SHALL enter WAIT and load a 4-bit counter with LATENCY; with LATENCY=0 it SHALL enter RESP directly.
REQ-017 In WAIT, the counter SHALL decrement once per cycle; the edge at which the counter equals 1 SHALL move the FSM to RESP.
REQ-018 rsp_valid_o SHALL therefore rise exactly LATENCY+1 cycles after the accept edge.
REQ-019 Error condition: addr[1:0]!=0 or addr[31:2]>=DEPTH; on error rsp_err_o=1, rsp_rdata_o=0, and no memory write occurs.
REQ-020 For a valid write, mem[addr[31:2]] SHALL be updated on the same edge the FSM enters RESP; rsp_rdata_o=0 and rsp_err_o=0.
REQ-021 For a valid read, rsp_rdata_o SHALL be registered from mem[addr[31:2]] on the same edge the FSM enters RESP.
REQ-022 In RESP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL hold stable until rsp_ready_i=1 at an edge; that edge returns the FSM to IDLE.
REQ-023 Only one request is outstanding at a time, so the minimum spacing between accepts is LATENCY+2 cycles; req_valid_i outside IDLE SHALL be ignored.
REQ-024 Request inputs SHALL be sampled only at the accept edge; later changes to them do not affect the transaction in flight.
REQ-025 A read from a word that has not been written since power-up returns an undefined value; the bench SHALL NOT check it.

Reset
REQ-026 While rst_i=0 at an edge: FSM=IDLE, counter=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0; req_ready_o is 1 in the first cycle after reset is released.
REQ-027 A reset during WAIT SHALL abort the transaction; a write not yet committed (REQ-020) SHALL NOT occur.
REQ-028 A reset during RESP SHALL drop the response.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-030 LATENCY=2: write 0x12345678 to addr 0x10 -> rsp_valid_o rises 3 cycles after accept with rsp_err_o=0; a following read of 0x10 returns 0x12345678.
REQ-031 Read addr 0x0000_0006 -> rsp_err_o=1, rsp_rdata_o=0; a write to addr 0x6 leaves every memory word unchanged.
REQ-032 DEPTH=128: write to addr 0x200 (word 128) -> rsp_err_o=1; a read of word 0 afterwards returns its prior value.
REQ-033 Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP -> outputs stay stable and req_ready_o stays 0; the handshake edge -> IDLE, with req_ready_o=1 the next cycle.
REQ-034 Write 0xAAAA5555 to addr 0x20, then assert rst_i=0 during WAIT -> all outputs reset; a later read of 0x20 returns the old value, not 0xAAAA5555.
REQ-035 LATENCY=0: a read accepted at edge N -> rsp_valid_o=1 after edge N+1; back-to-back requests are accepted every 2 cycles while rsp_ready_i=1.
